// File: rtl/fmr_pkg.sv
// Shared types and constants for the five-modular-redundancy vote path.
package fmr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VOTE,
    OUTPUT,
    FAIL
  } state_t;

  localparam int N_MOD      = 5;
  localparam int MIN_QUORUM = 3;

endpackage

// File: rtl/fmr_majority.sv
// Combinational masked majority over five result bits; only bits with part[i]=1 vote.
module fmr_majority
  import fmr_pkg::*;
(
  input  logic [N_MOD-1:0] data,
  input  logic [N_MOD-1:0] part,
  output logic             z,
  output logic             tie,
  output logic [2:0]       n
);

  function automatic logic [2:0] popcount(input logic [N_MOD-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < N_MOD; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  logic [2:0] ones;
  logic [3:0] twice_ones;
  logic [3:0] n_ext;

  always_comb begin
    n          = popcount(part);
    ones       = popcount(data & part);
    twice_ones = {ones, 1'b0};
    n_ext      = {1'b0, n};
    z          = (twice_ones > n_ext);
    tie        = (twice_ones == n_ext);
  end

endmodule

// File: rtl/fmr_vote_ctrl.sv
// Round controller: collects one bit per redundant module, votes over the
// participating ones, retires chronic disagreers and hands the result downstream.
module fmr_vote_ctrl
  import fmr_pkg::*;
#(
  parameter int THRESH  = 3,
  parameter int CNT_W   = 2,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_MOD-1:0] mod_valid,
  input  logic [N_MOD-1:0] mod_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_z,
  output logic             out_tie,
  output logic [N_MOD-1:0] disagree,
  output logic [N_MOD-1:0] mask,
  output logic             fail,
  output logic             busy,
  input  logic             clear_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;

  logic [N_MOD-1:0] latched;
  logic [N_MOD-1:0] data_q;
  logic [CNT_W-1:0] cnt     [N_MOD];
  logic [CNT_W-1:0] cnt_nxt [N_MOD];
  logic [N_MOD-1:0] mask_nxt;
  logic [TO_W-1:0]  timer;

  logic [N_MOD-1:0] part;
  logic [N_MOD-1:0] capture;
  logic [N_MOD-1:0] miss;
  logic             all_in;
  logic             vote_z;
  logic             vote_tie;
  logic [2:0]       vote_n;

  assign part    = ~mask & latched;
  assign capture = mod_valid & ~mask & ~latched;
  // Include this cycle's strobes so a full set on the first COLLECT cycle votes next cycle.
  assign all_in  = &(latched | capture | mask);
  assign miss    = ~mask & (~latched | (data_q ^ {N_MOD{vote_z}}));

  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);

  fmr_majority u_majority (
    .data (data_q),
    .part (part),
    .z    (vote_z),
    .tie  (vote_tie),
    .n    (vote_n)
  );

  always_comb begin
    mask_nxt = mask;
    for (int i = 0; i < N_MOD; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!mask[i]) begin
        if (miss[i]) cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CNT_W'(1);
        else         cnt_nxt[i] = '0;
      end
      if (cnt_nxt[i] >= CNT_W'(THRESH)) mask_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (all_in || (timer == TO_W'(TIMEOUT))) state_nxt = VOTE;
      VOTE:    state_nxt = (vote_n < 3'(MIN_QUORUM)) ? FAIL : OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = IDLE;
      FAIL:    if (clear_mask) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      latched  <= '0;
      timer    <= '0;
      mask     <= '0;
      fail     <= 1'b0;
      out_z    <= 1'b0;
      out_tie  <= 1'b0;
      disagree <= '0;
      for (int i = 0; i < N_MOD; i++) cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      disagree <= '0;
      case (state)
        IDLE: begin
          if (clear_mask) begin
            mask <= '0;
            fail <= 1'b0;
            for (int i = 0; i < N_MOD; i++) cnt[i] <= '0;
          end
          if (start) begin
            latched <= '0;
            timer   <= '0;
          end
        end
        COLLECT: begin
          latched <= latched | capture;
          timer   <= timer + TO_W'(1);
        end
        VOTE: begin
          if (vote_n < 3'(MIN_QUORUM)) begin
            fail <= 1'b1;
          end else begin
            out_z   <= vote_z;
            out_tie <= vote_tie;
            if (!vote_tie) begin
              cnt      <= cnt_nxt;
              mask     <= mask_nxt;
              disagree <= miss;
            end
          end
        end
        FAIL: begin
          if (clear_mask) begin
            mask <= '0;
            fail <= 1'b0;
            for (int i = 0; i < N_MOD; i++) cnt[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Result bits carry no reset; only the first strobe of a round is kept.
  always_ff @(posedge clk) begin
    if (state == COLLECT) data_q <= (data_q & ~capture) | (mod_data & capture);
  end

endmodule

// File: tb/tb_fmr_vote_ctrl.sv
// Scoreboard bench for fmr_vote_ctrl: a behavioural vote model queues expected round results.
module tb_fmr_vote_ctrl;

  localparam int THRESH  = 3;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] mod_valid;
  logic [4:0] mod_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_z;
  logic       out_tie;
  logic [4:0] disagree;
  logic [4:0] mask;
  logic       fail;
  logic       busy;
  logic       clear_mask;

  fmr_vote_ctrl #(.THRESH(THRESH), .CNT_W(2), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mod_valid  (mod_valid),
    .mod_data   (mod_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_tie    (out_tie),
    .disagree   (disagree),
    .mask       (mask),
    .fail       (fail),
    .busy       (busy),
    .clear_mask (clear_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       z;
    logic       tie;
    logic [4:0] dis;
    logic [4:0] msk;
    logic       fl;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t ex;

  int checks   = 0;
  int failures = 0;

  logic [4:0] m_mask;
  int         m_cnt[5];
  logic       m_fail;

  int         obs_lat;
  logic       obs_z, obs_tie, obs_fail;
  logic [4:0] obs_dis, obs_mask;

  task automatic model_clear();
    m_mask = '0;
    m_fail = 1'b0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endtask

  task automatic do_clear();
    clear_mask = 1'b1;
    @(posedge clk); #1;
    clear_mask = 1'b0;
    model_clear();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Predict the round, queue the prediction, drive it, capture the first result cycle.
  task automatic run_round(input logic [4:0] v, input logic [4:0] d,
                           input logic [4:0] late_v, input logic [4:0] late_d);
    exp_t       e;
    logic [4:0] p;
    int         n, ones;
    logic       miss;
    e.lat = ((v | m_mask) == 5'h1f) ? 3 : TIMEOUT + 3;
    p     = v & ~m_mask;
    n     = $countones(p);
    ones  = $countones(d & p);
    e.z = 1'b0; e.tie = 1'b0; e.dis = '0; e.fl = 1'b0;
    if (n < 3) begin
      e.fl   = 1'b1;
      m_fail = 1'b1;
    end else begin
      e.z   = (2 * ones > n);
      e.tie = (2 * ones == n);
      if (!e.tie) begin
        for (int i = 0; i < 5; i++) begin
          if (!m_mask[i]) begin
            miss     = !v[i] || (d[i] != e.z);
            e.dis[i] = miss;
            m_cnt[i] = miss ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : 0;
          end
        end
        for (int i = 0; i < 5; i++) if (m_cnt[i] >= THRESH) m_mask[i] = 1'b1;
      end
    end
    e.msk = m_mask;
    exp_q.push_back(e);

    obs_lat  = -1;
    start    = 1'b1;
    mod_data = d;
    for (int cyc = 1; cyc <= TIMEOUT + 8; cyc++) begin
      @(posedge clk); #1;
      if (out_valid || fail) begin
        obs_lat = cyc; obs_z = out_z; obs_tie = out_tie;
        obs_dis = disagree; obs_mask = mask; obs_fail = fail;
        break;
      end
      if (cyc == 1) begin
        start     = 1'b0;
        mod_valid = v;
      end else if (cyc == 2) begin
        mod_valid = late_v;
        mod_data  = late_d;
      end else begin
        mod_valid = '0;
      end
    end
    start     = 1'b0;
    mod_valid = '0;
    ex = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; mod_valid = '0; mod_data = '0; out_ready = 0; clear_mask = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({out_valid, out_z, out_tie, fail, busy} !== 5'b0) begin failures++; $display("FAIL reset_ctrl: got %b want 00000", {out_valid, out_z, out_tie, fail, busy}); end
    checks++; if ({disagree, mask} !== 10'b0) begin failures++; $display("FAIL reset_vec: got %b want 0", {disagree, mask}); end
  endtask

  task automatic test_basic_vote();
    run_round(5'b11111, 5'b00111, 5'b0, 5'b0);
    checks++; if (obs_lat !== ex.lat) begin failures++; $display("FAIL basic_latency: got %0d want %0d", obs_lat, ex.lat); end
    checks++; if ({obs_z, obs_tie} !== {ex.z, ex.tie}) begin failures++; $display("FAIL basic_z_tie: got %b want %b", {obs_z, obs_tie}, {ex.z, ex.tie}); end
    checks++; if (obs_dis !== ex.dis) begin failures++; $display("FAIL basic_disagree: got %b want %b", obs_dis, ex.dis); end
    checks++; if (obs_mask !== ex.msk) begin failures++; $display("FAIL basic_mask: got %b want %b", obs_mask, ex.msk); end
    @(posedge clk); #1;
    checks++; if ({out_valid, disagree} !== 6'b100000) begin failures++; $display("FAIL basic_pulse: got %b want 100000", {out_valid, disagree}); end
    accept();
    checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL basic_accept: got %b want 00", {out_valid, busy}); end
  endtask

  task automatic test_mask_retire();
    do_clear();
    for (int r = 0; r < 3; r++) begin
      run_round(5'b11111, 5'b10000, 5'b0, 5'b0);
      checks++; if ({obs_z, obs_dis} !== {ex.z, ex.dis}) begin failures++; $display("FAIL retire_r%0d_vote: got %b want %b", r, {obs_z, obs_dis}, {ex.z, ex.dis}); end
      checks++; if (obs_mask !== ex.msk) begin failures++; $display("FAIL retire_r%0d_mask: got %b want %b", r, obs_mask, ex.msk); end
      accept();
    end
    run_round(5'b11111, 5'b10111, 5'b0, 5'b0);
    checks++; if ({obs_z, obs_tie, obs_dis} !== {ex.z, ex.tie, ex.dis}) begin failures++; $display("FAIL retire_after: got %b want %b", {obs_z, obs_tie, obs_dis}, {ex.z, ex.tie, ex.dis}); end
    accept();
  endtask

  task automatic test_timeout();
    run_round(5'b01011, 5'b11011, 5'b00011, 5'b11000);
    checks++; if (obs_lat !== ex.lat) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", obs_lat, ex.lat); end
    checks++; if ({obs_z, obs_dis} !== {ex.z, ex.dis}) begin failures++; $display("FAIL timeout_vote: got %b want %b", {obs_z, obs_dis}, {ex.z, ex.dis}); end
    accept();
  endtask

  task automatic test_tie();
    run_round(5'b11111, 5'b00011, 5'b0, 5'b0);
    checks++; if ({obs_tie, obs_z, obs_dis} !== {ex.tie, ex.z, ex.dis}) begin failures++; $display("FAIL tie_vote: got %b want %b", {obs_tie, obs_z, obs_dis}, {ex.tie, ex.z, ex.dis}); end
    accept();
    for (int r = 0; r < 2; r++) begin
      run_round(5'b11111, 5'b11011, 5'b0, 5'b0);
      checks++; if ({obs_dis, obs_mask} !== {ex.dis, ex.msk}) begin failures++; $display("FAIL tie_cnt_r%0d: got %b want %b", r, {obs_dis, obs_mask}, {ex.dis, ex.msk}); end
      accept();
    end
  endtask

  task automatic test_back_to_back();
    run_round(5'b11111, 5'b11111, 5'b0, 5'b0);
    checks++; if ({obs_lat, obs_z} !== {ex.lat, ex.z}) begin failures++; $display("FAIL hold_first: got %0d/%b want %0d/%b", obs_lat, obs_z, ex.lat, ex.z); end
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      @(posedge clk); #1;
      checks++; if ({out_valid, out_z, out_tie, disagree} !== {1'b1, ex.z, ex.tie, 5'b0}) begin failures++; $display("FAIL hold_c%0d: got %b want %b", c, {out_valid, out_z, out_tie, disagree}, {1'b1, ex.z, ex.tie, 5'b0}); end
    end
    start = 1'b0;
    accept();
    checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL hold_release: got %b want 00", {out_valid, busy}); end
  endtask

  task automatic test_fail_clear();
    do_clear();
    for (int r = 0; r < 3; r++) begin run_round(5'b11111, 5'b11100, 5'b0, 5'b0); accept(); end
    for (int r = 0; r < 3; r++) begin run_round(5'b11111, 5'b11000, 5'b0, 5'b0); accept(); end
    checks++; if (mask !== m_mask) begin failures++; $display("FAIL fail_premask: got %b want %b", mask, m_mask); end
    run_round(5'b11111, 5'b11000, 5'b0, 5'b0);
    checks++; if ({obs_lat, obs_fail} !== {ex.lat, ex.fl}) begin failures++; $display("FAIL fail_enter: got %0d/%b want %0d/%b", obs_lat, obs_fail, ex.lat, ex.fl); end
    for (int c = 0; c < 4; c++) begin
      start = ~c[0];
      @(posedge clk); #1;
      checks++; if ({fail, busy, out_valid} !== 3'b110) begin failures++; $display("FAIL fail_hold_c%0d: got %b want 110", c, {fail, busy, out_valid}); end
    end
    start = 1'b0;
    do_clear();
    checks++; if ({mask, fail, busy} !== 7'b0) begin failures++; $display("FAIL fail_clear: got %b want 0", {mask, fail, busy}); end
  endtask

  task automatic test_async_reset();
    for (int r = 0; r < 3; r++) begin run_round(5'b11111, 5'b10000, 5'b0, 5'b0); accept(); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++; if ({busy, mask} !== {1'b1, m_mask}) begin failures++; $display("FAIL arst_pre: got %b want %b", {busy, mask}, {1'b1, m_mask}); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_z, out_tie, fail, busy, disagree, mask} !== 15'b0) begin failures++; $display("FAIL arst_now: got %b want 0", {out_valid, out_z, out_tie, fail, busy, disagree, mask}); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++; if ({out_valid, busy} !== 2'b00) begin failures++; $display("FAIL arst_after: got %b want 00", {out_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic_vote();
    test_mask_retire();
    test_timeout();
    test_tie();
    test_back_to_back();
    test_fail_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
